// File: rtl/err_stat_if.sv
// err_stat_if -- bundles the sample stream, control pulses and statistics
// outputs of err_stat_acc.
//   master: producer/consumer side (drives samples, clear, snap_req, snap_ack)
//   slave : accumulator side (drives in_ready, snap_valid and the statistics)
// Ports carried:
//   in_valid/in_ready/a/b/prod_apx  sample handshake and payload
//   clear                           zero all statistics
//   snap_req/snap_valid/snap_ack    snapshot handshake
//   sample_cnt/err_cnt/sum_ed/max_ed/sum_err/sat  statistics
interface err_stat_if #(
    parameter int W     = 8,
    parameter int CNT_W = 17,
    parameter int SUM_W = 40
);
    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       a;
    logic [W-1:0]       b;
    logic [2*W-1:0]     prod_apx;
    logic               clear;
    logic               snap_req;
    logic               snap_valid;
    logic               snap_ack;
    logic [CNT_W-1:0]   sample_cnt;
    logic [CNT_W-1:0]   err_cnt;
    logic [SUM_W-1:0]   sum_ed;
    logic [2*W-1:0]     max_ed;
    logic [SUM_W:0]     sum_err;
    logic               sat;

    modport master (
        output in_valid, a, b, prod_apx, clear, snap_req, snap_ack,
        input  in_ready, snap_valid, sample_cnt, err_cnt, sum_ed, max_ed, sum_err, sat
    );

    modport slave (
        input  in_valid, a, b, prod_apx, clear, snap_req, snap_ack,
        output in_ready, snap_valid, sample_cnt, err_cnt, sum_ed, max_ed, sum_err, sat
    );
endinterface

// File: rtl/err_stat_acc.sv
// err_stat_acc -- pipelined error-statistics accumulator for an approximate
// 8x8 multiplier. Each accepted sample (a, b, prod_apx) goes through:
//   S1: exact = a*b, prod_apx registered
//   S2: ED = |exact - prod_apx| and ED != 0 registered
//   S3: sample_cnt, err_cnt, sum_ed, max_ed updated (saturating, sticky sat)
// A RUN/DRAIN/HOLD FSM drains the pipeline on snap_req and freezes the
// statistics with snap_valid until snap_ack. clear (or rst) zeroes everything.
// Ports: clk, rst (synchronous, active high), bus (err_stat_if.slave).
// Optional feature macro ERR_SIGNED_SUM_EN: when defined, a signed sum of
// (prod_apx - exact) is accumulated into sum_err with signed saturation;
// otherwise sum_err is tied to zero.
module err_stat_acc #(
    parameter int W     = 8,
    parameter int CNT_W = 17,
    parameter int SUM_W = 40
) (
    input  logic      clk,
    input  logic      rst,
    err_stat_if.slave bus
);
    localparam int PW = 2 * W;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               snap_valid_q, snap_valid_d;
    logic               s1_v_q, s1_v_d;
    logic [PW-1:0]      exact_q, exact_d;
    logic [PW-1:0]      apx_q, apx_d;
    logic               s2_v_q, s2_v_d;
    logic [PW-1:0]      ed_q, ed_d;
    logic               nz_q, nz_d;
    logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [SUM_W-1:0]   sum_ed_q, sum_ed_d;
    logic [PW-1:0]      max_ed_q, max_ed_d;
    logic               sat_q, sat_d;
    logic               take_s;
    logic [SUM_W:0]     sum_ed_ext_s;
`ifdef ERR_SIGNED_SUM_EN
    logic [PW:0]        serr_q, serr_d;
    logic [SUM_W:0]     sum_err_q, sum_err_d;
    logic [SUM_W+1:0]   sum_err_ext_s;
`endif

    assign take_s = bus.in_valid && in_ready_q;

    // S1/S2 datapath and valid bits; clear flushes the valid bits only.
    always_comb begin
        exact_d = exact_q;
        apx_d   = apx_q;
        ed_d    = ed_q;
        nz_d    = nz_q;
        s1_v_d  = take_s && !bus.clear;
        s2_v_d  = s1_v_q && !bus.clear;
`ifdef ERR_SIGNED_SUM_EN
        serr_d  = serr_q;
`endif
        if (take_s) begin
            exact_d = {{W{1'b0}}, bus.a} * {{W{1'b0}}, bus.b};
            apx_d   = bus.prod_apx;
        end else begin
            exact_d = exact_q;
            apx_d   = apx_q;
        end
        if (s1_v_q) begin
            if (exact_q >= apx_q) begin
                ed_d = exact_q - apx_q;
            end else begin
                ed_d = apx_q - exact_q;
            end
            nz_d = (exact_q != apx_q);
`ifdef ERR_SIGNED_SUM_EN
            // Two's-complement difference on PW+1 bits covers the full range.
            serr_d = {1'b0, apx_q} - {1'b0, exact_q};
`endif
        end else begin
            nz_d = nz_q;
        end
    end

    // S3 saturating statistics update; clear has priority and zeroes all.
    always_comb begin
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        sum_ed_d     = sum_ed_q;
        max_ed_d     = max_ed_q;
        sat_d        = sat_q;
        sum_ed_ext_s = {1'b0, sum_ed_q} + {{(SUM_W + 1 - PW){1'b0}}, ed_q};
`ifdef ERR_SIGNED_SUM_EN
        sum_err_d     = sum_err_q;
        sum_err_ext_s = {sum_err_q[SUM_W], sum_err_q}
                      + {{(SUM_W + 1 - PW){serr_q[PW]}}, serr_q};
`endif
        if (s2_v_q) begin
            if (sample_cnt_q == {CNT_W{1'b1}}) begin
                sat_d = 1'b1;
            end else begin
                sample_cnt_d = sample_cnt_q + {{(CNT_W - 1){1'b0}}, 1'b1};
            end
            if (nz_q && (err_cnt_q == {CNT_W{1'b1}})) begin
                sat_d = 1'b1;
            end else if (nz_q) begin
                err_cnt_d = err_cnt_q + {{(CNT_W - 1){1'b0}}, 1'b1};
            end else begin
                err_cnt_d = err_cnt_q;
            end
            if (sum_ed_ext_s[SUM_W]) begin
                sum_ed_d = {SUM_W{1'b1}};
                sat_d    = 1'b1;
            end else begin
                sum_ed_d = sum_ed_ext_s[SUM_W-1:0];
            end
            if (ed_q > max_ed_q) begin
                max_ed_d = ed_q;
            end else begin
                max_ed_d = max_ed_q;
            end
`ifdef ERR_SIGNED_SUM_EN
            // Top two bits disagreeing means the signed range was exceeded.
            case (sum_err_ext_s[SUM_W+1:SUM_W])
                2'b01: begin
                    sum_err_d = {1'b0, {SUM_W{1'b1}}};
                    sat_d     = 1'b1;
                end
                2'b10: begin
                    sum_err_d = {1'b1, {SUM_W{1'b0}}};
                    sat_d     = 1'b1;
                end
                default: sum_err_d = sum_err_ext_s[SUM_W:0];
            endcase
`endif
        end else begin
            sat_d = sat_q;
        end
        if (bus.clear) begin
            sample_cnt_d = {CNT_W{1'b0}};
            err_cnt_d    = {CNT_W{1'b0}};
            sum_ed_d     = {SUM_W{1'b0}};
            max_ed_d     = {PW{1'b0}};
            sat_d        = 1'b0;
`ifdef ERR_SIGNED_SUM_EN
            sum_err_d    = {(SUM_W + 1){1'b0}};
`endif
        end else begin
            sat_d = sat_d;
        end
    end

    // Snapshot FSM next state and registered handshake outputs.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (bus.snap_req) state_d = ST_DRAIN;
                else              state_d = ST_RUN;
            end
            ST_DRAIN: begin
                // S2 empty means its last sample has already been committed.
                if (!s1_v_q && !s2_v_q) state_d = ST_HOLD;
                else                    state_d = ST_DRAIN;
            end
            ST_HOLD: begin
                if (bus.snap_ack) state_d = ST_RUN;
                else              state_d = ST_HOLD;
            end
            default: state_d = ST_RUN;
        endcase
        if (bus.clear) begin
            state_d = ST_RUN;
        end else begin
            state_d = state_d;
        end
        in_ready_d   = (state_d == ST_RUN) && (sample_cnt_d != {CNT_W{1'b1}});
        snap_valid_d = (state_d == ST_HOLD);
    end

    // State, pipeline and statistics registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            in_ready_q   <= 1'b1;
            snap_valid_q <= 1'b0;
            s1_v_q       <= 1'b0;
            exact_q      <= {PW{1'b0}};
            apx_q        <= {PW{1'b0}};
            s2_v_q       <= 1'b0;
            ed_q         <= {PW{1'b0}};
            nz_q         <= 1'b0;
            sample_cnt_q <= {CNT_W{1'b0}};
            err_cnt_q    <= {CNT_W{1'b0}};
            sum_ed_q     <= {SUM_W{1'b0}};
            max_ed_q     <= {PW{1'b0}};
            sat_q        <= 1'b0;
`ifdef ERR_SIGNED_SUM_EN
            serr_q       <= {(PW + 1){1'b0}};
            sum_err_q    <= {(SUM_W + 1){1'b0}};
`endif
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            snap_valid_q <= snap_valid_d;
            s1_v_q       <= s1_v_d;
            exact_q      <= exact_d;
            apx_q        <= apx_d;
            s2_v_q       <= s2_v_d;
            ed_q         <= ed_d;
            nz_q         <= nz_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            sum_ed_q     <= sum_ed_d;
            max_ed_q     <= max_ed_d;
            sat_q        <= sat_d;
`ifdef ERR_SIGNED_SUM_EN
            serr_q       <= serr_d;
            sum_err_q    <= sum_err_d;
`endif
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.snap_valid = snap_valid_q;
    assign bus.sample_cnt = sample_cnt_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.sum_ed     = sum_ed_q;
    assign bus.max_ed     = max_ed_q;
    assign bus.sat        = sat_q;
`ifdef ERR_SIGNED_SUM_EN
    assign bus.sum_err    = sum_err_q;
`else
    assign bus.sum_err    = {(SUM_W + 1){1'b0}};
`endif
endmodule

// File: tb/tb_err_stat_acc.sv
// tb_err_stat_acc -- directed bench for err_stat_acc: a full-size instance
// (CNT_W=17) for the functional cases and an exhaustive sweep, plus a CNT_W=4
// instance for counter saturation. Inputs change on the falling edge and
// outputs are sampled on the falling edge.
module tb_err_stat_acc;
    localparam int W     = 8;
    localparam int CNT_W = 17;
    localparam int SUM_W = 40;
    localparam int CNT_S = 4;

    logic clk = 1'b0;
    logic rst;
    int   vec_cnt  = 0;
    int   miss_cnt = 0;

    always #5 clk = ~clk;

    err_stat_if #(.W(W), .CNT_W(CNT_W), .SUM_W(SUM_W)) bus ();
    err_stat_if #(.W(W), .CNT_W(CNT_S), .SUM_W(SUM_W)) bus_s ();

    err_stat_acc #(.W(W), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    err_stat_acc #(.W(W), .CNT_W(CNT_S), .SUM_W(SUM_W)) dut_s (
        .clk(clk), .rst(rst), .bus(bus_s)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] apx_of(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] e;
        e = 16'(x) * 16'(y);
        if (x == y) return e >> 1;
        else        return e ^ (16'(x & y) & 16'h0007);
    endfunction

    task automatic check_stats(input string tag, input logic [63:0] cnt, input logic [63:0] err,
                               input logic [63:0] sum, input logic [63:0] mx);
        check_val({tag, ".sample_cnt"}, 64'(bus.sample_cnt), cnt);
        check_val({tag, ".err_cnt"},    64'(bus.err_cnt),    err);
        check_val({tag, ".sum_ed"},     64'(bus.sum_ed),     sum);
        check_val({tag, ".max_ed"},     64'(bus.max_ed),     mx);
    endtask

    task automatic check_sum_err(input string tag, input longint exp);
        longint got;
        got = longint'($signed(bus.sum_err));
`ifdef ERR_SIGNED_SUM_EN
        check_val({tag, ".sum_err"}, got, exp);
`else
        check_val({tag, ".sum_err"}, got, 64'd0);
        if (exp == 64'd0) got = 64'd0;
`endif
    endtask

    // Called at the falling edge of the cycle after snap_req was sampled.
    task automatic wait_snap(input string tag);
        int k;
        check_val({tag, ".in_ready_drain"}, 64'(bus.in_ready), 64'd0);
        k = 1;
        while (!bus.snap_valid && k < 8) begin
            @(negedge clk);
            k++;
        end
        check_val({tag, ".snap_in_4"}, 64'(bus.snap_valid && (k <= 4)), 64'd1);
    endtask

    task automatic take_snap(input string tag);
        bus.snap_req = 1'b1;
        @(negedge clk);
        bus.snap_req = 1'b0;
        wait_snap(tag);
    endtask

    task automatic do_ack(input string tag);
        bus.snap_ack = 1'b1;
        @(negedge clk);
        bus.snap_ack = 1'b0;
        check_val({tag, ".snap_valid_drop"}, 64'(bus.snap_valid), 64'd0);
        check_val({tag, ".in_ready_back"},   64'(bus.in_ready),   64'd1);
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [15:0] p);
        bus.in_valid = 1'b1;
        bus.a = x;
        bus.b = y;
        bus.prod_apx = p;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        longint m_err;
        longint m_sum;
        longint m_max;
        longint m_serr;
        longint ex;
        longint ed;
        logic [7:0] x;
        logic [7:0] y;
        logic [15:0] p;

        bus.in_valid = 1'b0; bus.a = 8'd0; bus.b = 8'd0; bus.prod_apx = 16'd0;
        bus.clear = 1'b0; bus.snap_req = 1'b0; bus.snap_ack = 1'b0;
        bus_s.in_valid = 1'b0; bus_s.a = 8'd0; bus_s.b = 8'd0; bus_s.prod_apx = 16'd0;
        bus_s.clear = 1'b0; bus_s.snap_req = 1'b0; bus_s.snap_ack = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check_val("rst.in_ready",   64'(bus.in_ready),   64'd1);
        check_val("rst.snap_valid", 64'(bus.snap_valid), 64'd0);
        check_val("rst.sat",        64'(bus.sat),        64'd0);
        check_stats("rst", 64'd0, 64'd0, 64'd0, 64'd0);
        check_sum_err("rst", 64'd0);

        // Single exact sample; visible in cycle t+3
        send(8'd3, 8'd5, 16'd15);
        check_val("lat.t1", 64'(bus.sample_cnt), 64'd0);
        @(negedge clk);
        check_val("lat.t2", 64'(bus.sample_cnt), 64'd0);
        @(negedge clk);
        check_val("lat.t3", 64'(bus.sample_cnt), 64'd1);
        take_snap("t1");
        check_stats("t1", 64'd1, 64'd0, 64'd0, 64'd0);
        check_val("t1.sat", 64'(bus.sat), 64'd0);
        do_ack("t1");

        // Two erroneous samples: ED 25 and 4, signed -25 and +4
        pulse_clear();
        send(8'd255, 8'd255, 16'd65000);
        send(8'd16, 8'd16, 16'd260);
        take_snap("t2");
        check_stats("t2", 64'd2, 64'd2, 64'd29, 64'd25);
        check_sum_err("t2", -64'sd21);
        do_ack("t2");

        // Snapshot with samples in flight; the sample of the snap_req cycle counts
        pulse_clear();
        bus.in_valid = 1'b1; bus.a = 8'd10; bus.b = 8'd10; bus.prod_apx = 16'd100;
        @(negedge clk);
        bus.a = 8'd20; bus.b = 8'd3; bus.prod_apx = 16'd50;
        @(negedge clk);
        bus.a = 8'd7; bus.b = 8'd9; bus.prod_apx = 16'd70;
        bus.snap_req = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.snap_req = 1'b0;
        wait_snap("t4");
        check_stats("t4", 64'd3, 64'd2, 64'd17, 64'd10);
        check_sum_err("t4", -64'sd3);
        // Held snap_req in HOLD must be ignored; outputs frozen without ack
        bus.snap_req = 1'b1;
        repeat (10) @(negedge clk);
        bus.snap_req = 1'b0;
        check_val("t4.hold_valid", 64'(bus.snap_valid), 64'd1);
        check_val("t4.hold_ready", 64'(bus.in_ready),   64'd0);
        check_stats("t4.hold", 64'd3, 64'd2, 64'd17, 64'd10);

        // clear together with snap_ack in HOLD
        bus.clear = 1'b1;
        bus.snap_ack = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        bus.snap_ack = 1'b0;
        check_val("t5.snap_valid", 64'(bus.snap_valid), 64'd0);
        check_val("t5.in_ready",   64'(bus.in_ready),   64'd1);
        check_val("t5.sat",        64'(bus.sat),        64'd0);
        check_stats("t5", 64'd0, 64'd0, 64'd0, 64'd0);
        check_sum_err("t5", 64'd0);

        // Exhaustive back-to-back sweep against the reference model
        m_err = 0; m_sum = 0; m_max = 0; m_serr = 0;
        for (int i = 0; i < 65536; i++) begin
            x = 8'(i >> 8);
            y = 8'(i);
            p = apx_of(x, y);
            ex = longint'(x) * longint'(y);
            ed = (ex > longint'(p)) ? ex - longint'(p) : longint'(p) - ex;
            m_serr += longint'(p) - ex;
            m_sum  += ed;
            if (ed != 0) m_err++;
            if (ed > m_max) m_max = ed;
            bus.in_valid = 1'b1; bus.a = x; bus.b = y; bus.prod_apx = p;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        take_snap("sweep");
        check_stats("sweep", 64'd65536, m_err, m_sum, m_max);
        check_val("sweep.sat", 64'(bus.sat), 64'd0);
        check_sum_err("sweep", m_serr);
        do_ack("sweep");

        // Small-counter instance: 16 exact samples into a 4-bit counter
        for (int i = 0; i < 16; i++) begin
            bus_s.in_valid = 1'b1;
            bus_s.a = 8'(i);
            bus_s.b = 8'd3;
            bus_s.prod_apx = 16'(i * 3);
            @(negedge clk);
        end
        bus_s.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_val("sat.sat",        64'(bus_s.sat),        64'd1);
        check_val("sat.in_ready",   64'(bus_s.in_ready),   64'd0);
        check_val("sat.sample_cnt", 64'(bus_s.sample_cnt), 64'd15);
        check_val("sat.err_cnt",    64'(bus_s.err_cnt),    64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
